// File: rtl/score_max_tracker_pkg.sv
// Shared types and defaults for the attention score datapath.
// Used by the score/max tracker and the exp/accumulate stage.
package score_max_tracker_pkg;

   localparam int MAX_EMBEDDING_DIM = 64;
   localparam int SCORE_SHIFT = $clog2(MAX_EMBEDDING_DIM) / 2;
   localparam int MAX_SEQ_LEN = 64;
   localparam int SCORE_W = 20;

   typedef enum logic {
      ROW_START,
      IN_ROW
   } row_state_e;

   typedef struct packed {
      logic signed [SCORE_W-1:0] score;
      logic signed [SCORE_W-1:0] max;
      logic signed [SCORE_W:0]   delta;
      logic                      first;
      logic                      last;
   } score_bundle_t;

endpackage

// File: rtl/score_max_tracker_handshake_reg.sv
// Single-entry valid/ready pipeline register.
// Accepts a new word in the same cycle the held word drains.
module score_max_tracker_handshake_reg
   import score_max_tracker_pkg::*;
#(
   parameter type T = score_bundle_t
) (
   input  logic clk,
   input  logic rst,
   input  logic vld_in,
   output logic rdy_out,
   input  T     data_in,
   output logic vld_out,
   input  logic rdy_in,
   output T     data_out
);

   assign rdy_out = !vld_out || rdy_in;

   // Load on accept, drop valid once the held word is taken.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_out  <= 1'b0;
         data_out <= '0;
      end else if (vld_in && rdy_out) begin
         vld_out  <= 1'b1;
         data_out <= data_in;
      end else if (rdy_in) begin
         vld_out  <= 1'b0;
      end
   end

endmodule

// File: rtl/score_max_tracker.sv
// Scales Q.K sums by 1/sqrt(d) and tracks the running row max.
// Feeds score, max, delta and row flags to the online softmax.
module score_max_tracker
   import score_max_tracker_pkg::*;
#(
   parameter int W_IN        = 20,
   parameter int SCALE_SHIFT = SCORE_SHIFT,
   parameter int NUM_KEYS    = MAX_SEQ_LEN,
   parameter int CNT_W       = $clog2(NUM_KEYS) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   vld_in,
   output logic                   rdy_out,
   input  logic signed [W_IN-1:0] sum_in,
   output logic                   vld_out,
   input  logic                   rdy_in,
   output logic signed [W_IN-1:0] score_out,
   output logic signed [W_IN-1:0] max_out,
   output logic signed [W_IN:0]   max_delta,
   output logic                   first_out,
   output logic                   last_out
);

   typedef struct packed {
      logic signed [W_IN-1:0] score;
      logic signed [W_IN-1:0] max;
      logic signed [W_IN:0]   delta;
      logic                   first;
      logic                   last;
   } bundle_t;

   row_state_e             state;
   logic [CNT_W-1:0]       cnt;
   logic signed [W_IN-1:0] row_max;
   logic signed [W_IN-1:0] scaled;
   logic signed [W_IN-1:0] new_max;
   logic signed [W_IN:0]   delta;
   logic                   is_last;
   logic                   accept;
   bundle_t                nxt;
   bundle_t                held;

   assign scaled = sum_in >>> SCALE_SHIFT;
   assign accept = vld_in && rdy_out;

   // New max, delta and end-of-row decision for the incoming sum.
   always_comb begin
      new_max = scaled;
      delta   = '0;
      is_last = (NUM_KEYS == 1);
      if (state == IN_ROW) begin
         new_max = (scaled > row_max) ? scaled : row_max;
         delta   = {row_max[W_IN-1], row_max}
                 - {new_max[W_IN-1], new_max};
         is_last = (cnt == CNT_W'(NUM_KEYS - 1));
      end
   end

   assign nxt.score = scaled;
   assign nxt.max   = new_max;
   assign nxt.delta = delta;
   assign nxt.first = (state == ROW_START);
   assign nxt.last  = is_last;

   // Row FSM: advances only when a sum is accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ROW_START;
         cnt     <= '0;
         row_max <= '0;
      end else if (accept) begin
         row_max <= new_max;
         if (is_last) begin
            state <= ROW_START;
            cnt   <= '0;
         end else begin
            state <= IN_ROW;
            cnt   <= cnt + 1'b1;
         end
      end
   end

   score_max_tracker_handshake_reg #(
      .T (bundle_t)
   ) u_out_reg (
      .clk      (clk),
      .rst      (rst),
      .vld_in   (vld_in),
      .rdy_out  (rdy_out),
      .data_in  (nxt),
      .vld_out  (vld_out),
      .rdy_in   (rdy_in),
      .data_out (held)
   );

   assign score_out = held.score;
   assign max_out   = held.max;
   assign max_delta = held.delta;
   assign first_out = held.first;
   assign last_out  = held.last;

endmodule

// File: tb/tb_score_max_tracker.sv
// Directed bench for score_max_tracker with a row-level model
// and a per-cycle output compare.
module tb_score_max_tracker;

   localparam int W_IN = 20;
   localparam int NUM_KEYS = 4;

   typedef struct {
      int score;
      int max;
      int delta;
      bit first;
      bit last;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   vld_in;
   logic                   rdy_out;
   logic signed [W_IN-1:0] sum_in;
   logic                   vld_out;
   logic                   rdy_in;
   logic signed [W_IN-1:0] score_out;
   logic signed [W_IN-1:0] max_out;
   logic signed [W_IN:0]   max_delta;
   logic                   first_out;
   logic                   last_out;

   int checks = 0;
   int failures = 0;

   exp_t q[$];
   exp_t log_q[$];
   exp_t tbl[18];
   int   m_key = 0;
   int   m_max = 0;

   score_max_tracker #(
      .W_IN        (W_IN),
      .SCALE_SHIFT (3),
      .NUM_KEYS    (NUM_KEYS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .vld_in    (vld_in),
      .rdy_out   (rdy_out),
      .sum_in    (sum_in),
      .vld_out   (vld_out),
      .rdy_in    (rdy_in),
      .score_out (score_out),
      .max_out   (max_out),
      .max_delta (max_delta),
      .first_out (first_out),
      .last_out  (last_out)
   );

   always #5 clk = ~clk;

   function automatic void model_push(input int s);
      exp_t e;
      int sc;
      sc = s >>> 3;
      e.score = sc;
      e.first = (m_key == 0);
      e.last = (m_key == NUM_KEYS - 1);
      if (e.first) begin
         e.max = sc;
         e.delta = 0;
      end else begin
         e.max = (sc > m_max) ? sc : m_max;
         e.delta = m_max - e.max;
      end
      m_max = e.max;
      m_key = e.last ? 0 : m_key + 1;
      q.push_back(e);
   endfunction

   // Per-cycle compare against the model; model updates on accept.
   always @(negedge clk) begin
      exp_t a;
      int s;
      if (rst !== 1'b1) begin
         q.delete();
         m_key = 0;
         m_max = 0;
      end else begin
         checks++;
         if (vld_out !== (q.size() != 0)) begin
            failures++;
            $display("FAIL vld_out got=%0b want=%0b t=%0t",
                     vld_out, q.size() != 0, $time);
         end
         checks++;
         if (rdy_out !== (!vld_out || rdy_in)) begin
            failures++;
            $display("FAIL rdy_out got=%0b want=%0b t=%0t",
                     rdy_out, !vld_out || rdy_in, $time);
         end
         a.score = score_out;
         a.max = max_out;
         a.delta = max_delta;
         a.first = first_out;
         a.last = last_out;
         if (vld_out === 1'b1 && q.size() != 0) begin
            checks++;
            if (a != q[0]) begin
               failures++;
               $display("FAIL data got=%0d/%0d/%0d/%0b/%0b want=%0d/%0d/%0d/%0b/%0b t=%0t",
                        a.score, a.max, a.delta, a.first, a.last,
                        q[0].score, q[0].max, q[0].delta,
                        q[0].first, q[0].last, $time);
            end
         end
         if (vld_out === 1'b1 && rdy_in === 1'b1) begin
            log_q.push_back(a);
            if (q.size() != 0) void'(q.pop_front());
         end
         if (vld_in === 1'b1 && rdy_out === 1'b1) begin
            s = sum_in;
            model_push(s);
         end
      end
   end

   task automatic send(input int s);
      bit acc;
      int guard;
      vld_in = 1'b1;
      sum_in = W_IN'(s);
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 50) begin
         @(negedge clk);
         acc = rdy_out;
         @(posedge clk);
         #2;
         guard++;
      end
      vld_in = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout sum=%0d got=no_accept want=accept", s);
      end
   endtask

   task automatic chk1(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   task automatic set_tbl(input int i, input int sc, input int mx,
                          input int dl, input bit f, input bit l);
      tbl[i].score = sc;
      tbl[i].max = mx;
      tbl[i].delta = dl;
      tbl[i].first = f;
      tbl[i].last = l;
   endtask

   initial begin
      set_tbl(0, 10, 10, 0, 1, 0);
      set_tbl(1, 2, 10, 0, 0, 0);
      set_tbl(2, 30, 30, -20, 0, 0);
      set_tbl(3, -1, 30, 0, 0, 1);
      set_tbl(4, 0, 0, 0, 1, 0);
      set_tbl(5, 3, 3, -3, 0, 0);
      set_tbl(6, 2, 3, 0, 0, 0);
      set_tbl(7, 6, 6, -3, 0, 1);
      set_tbl(8, -65536, -65536, 0, 1, 0);
      set_tbl(9, 65535, 65535, -131071, 0, 0);
      set_tbl(10, -2, 65535, 0, 0, 0);
      set_tbl(11, -2, 65535, 0, 0, 1);
      set_tbl(12, 1, 1, 0, 1, 0);
      set_tbl(13, 1, 1, 0, 0, 0);
      set_tbl(14, 1, 1, 0, 1, 0);
      set_tbl(15, 1, 1, 0, 0, 0);
      set_tbl(16, 1, 1, 0, 0, 0);
      set_tbl(17, 1, 1, 0, 0, 1);

      rst = 1'b0;
      vld_in = 1'b1;
      sum_in = 20'sd80;
      rdy_in = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("rst_vld_out", vld_out, 0);
      chk1("rst_rdy_out", rdy_out, 1);
      chk1("rst_score", score_out, 0);
      chk1("rst_max", max_out, 0);
      chk1("rst_delta", max_delta, 0);
      chk1("rst_first", first_out, 0);
      chk1("rst_last", last_out, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      vld_in = 1'b0;

      send(80);
      send(16);
      send(240);
      send(-8);

      send(0);
      rdy_in = 1'b0;
      vld_in = 1'b1;
      sum_in = 20'sd24;
      repeat (3) begin
         @(negedge clk);
         chk1("stall_rdy_out", rdy_out, 0);
         chk1("stall_score", score_out, 0);
         chk1("stall_first", first_out, 1);
         @(posedge clk);
         #2;
      end
      rdy_in = 1'b1;
      send(24);
      send(16);
      send(48);

      send(-524288);
      send(524287);
      send(-9);
      send(-9);

      send(8);
      send(8);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (4) send(8);

      begin
         int guard;
         guard = 0;
         while ((q.size() != 0 || vld_out === 1'b1) && guard < 50) begin
            @(posedge clk);
            guard++;
         end
         @(negedge clk);
         chk1("drain_queue", q.size(), 0);
      end

      chk1("log_count", log_q.size(), 18);
      for (int i = 0; i < 18; i++) begin
         checks++;
         if (i >= log_q.size()) begin
            failures++;
            $display("FAIL log%0d got=missing want=%0d/%0d/%0d",
                     i, tbl[i].score, tbl[i].max, tbl[i].delta);
         end else if (log_q[i] != tbl[i]) begin
            failures++;
            $display("FAIL log%0d got=%0d/%0d/%0d/%0b/%0b want=%0d/%0d/%0d/%0b/%0b",
                     i, log_q[i].score, log_q[i].max, log_q[i].delta,
                     log_q[i].first, log_q[i].last,
                     tbl[i].score, tbl[i].max, tbl[i].delta,
                     tbl[i].first, tbl[i].last);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
